// File: rtl/gshare_predictor_param.sv
// Parametrised global-history branch predictor with gshare/gselect/bimodal indexing,
// a speculative GHR repaired from the architectural GHR on mispredict, and saturating stats.
module gshare_predictor_param #(
  parameter int PC_W   = 8,
  parameter int IDX_W  = 8,
  parameter int GHR_W  = 8,
  parameter int CTR_W  = 2,
  parameter int MODE   = 0,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pred_req,
  input  logic [PC_W-1:0]   pred_pc,
  output logic              pred_valid,
  output logic              prediction,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic              upd_mispredict,
  input  logic              stat_clear,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred,
  output logic [GHR_W-1:0]  spec_ghr_o
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [CTR_W-1:0]  CTR_INIT = CTR_W'(2 ** (CTR_W - 1) - 1);
  localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
  localparam logic [CTR_W-1:0]  CTR_ONE  = CTR_W'(1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

  logic [CTR_W-1:0] pht [DEPTH];
  logic [GHR_W-1:0] spec_ghr;
  logic [GHR_W-1:0] arch_ghr;
  logic [IDX_W-1:0] ghr_ext;
  logic [IDX_W-1:0] idx;
  logic             pred_bit;
  logic [CTR_W-1:0] ctr_cur;
  logic [CTR_W-1:0] ctr_next;
  logic             recover;

  generate
    if (GHR_W >= IDX_W) begin : g_ghr_trunc
      assign ghr_ext = spec_ghr[IDX_W-1:0];
    end else begin : g_ghr_zext
      assign ghr_ext = {{(IDX_W - GHR_W){1'b0}}, spec_ghr};
    end

    if (MODE == 0) begin : g_gshare
      assign idx = pred_pc[IDX_W-1:0] ^ ghr_ext;
    end else if (MODE == 1) begin : g_gselect
      assign idx = {pred_pc[IDX_W-IDX_W/2-1:0], ghr_ext[IDX_W/2-1:0]};
    end else begin : g_bimodal
      assign idx = pred_pc[IDX_W-1:0];
    end
  endgenerate

  // Read happens before this edge's update lands, so a same-index update is not forwarded.
  assign pred_bit = pht[idx][CTR_W-1];
  assign ctr_cur  = pht[upd_idx];
  assign recover  = upd_valid & upd_mispredict;

  always_comb begin
    ctr_next = ctr_cur;
    if (upd_taken) begin
      if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + CTR_ONE;
    end else begin
      if (ctr_cur != '0) ctr_next = ctr_cur - CTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) pht[i] <= CTR_INIT;
    end else if (upd_valid) begin
      pht[upd_idx] <= ctr_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pred_valid <= 1'b0;
      prediction <= 1'b0;
      pred_idx   <= '0;
    end else begin
      pred_valid <= pred_req;
      if (pred_req) begin
        prediction <= pred_bit;
        pred_idx   <= idx;
      end
    end
  end

  // Recovery overrides the speculative shift of a prediction issued in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spec_ghr <= '0;
      arch_ghr <= '0;
    end else begin
      if (upd_valid) arch_ghr <= {arch_ghr[GHR_W-2:0], upd_taken};
      if (recover) begin
        spec_ghr <= {arch_ghr[GHR_W-2:0], upd_taken};
      end else if (pred_req) begin
        spec_ghr <= {spec_ghr[GHR_W-2:0], pred_bit};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (stat_clear) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (upd_valid) begin
      if (stat_branches != STAT_MAX) stat_branches <= stat_branches + STAT_ONE;
      if (upd_mispredict && (stat_mispred != STAT_MAX)) stat_mispred <= stat_mispred + STAT_ONE;
    end
  end

  assign spec_ghr_o = spec_ghr;

endmodule

// File: tb/tb_gshare_predictor_param.sv
// Directed bench: three predictor instances (gshare, gselect with narrow stats, bimodal)
// share one stimulus stream; expectations are hand-computed or from a small gshare model.
module tb_gshare_predictor_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, pred_req, upd_valid, upd_taken, upd_mispredict, stat_clear;
  logic [7:0] pred_pc, upd_idx;
  logic       pv0, pv1, pv2, pr0, pr1, pr2;
  logic [7:0] pi0, pi1, pi2, sg0, sg1, sg2;
  logic [31:0] sb0, sm0, sb2, sm2;
  logic [3:0]  sb1, sm1;

  int checks = 0;
  int errors = 0;
  bit verbose = 1'b1;

  logic [1:0] m_pht [256];
  logic [7:0] m_ghr, m_idx;
  logic       m_pred, tk;
  int         m_mp, diverge;

  gshare_predictor_param #(.MODE(0)) dut0 (
    .clk(clk), .reset(reset), .pred_req(pred_req), .pred_pc(pred_pc),
    .pred_valid(pv0), .prediction(pr0), .pred_idx(pi0),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .stat_clear(stat_clear), .stat_branches(sb0), .stat_mispred(sm0), .spec_ghr_o(sg0));

  gshare_predictor_param #(.MODE(1), .STAT_W(4)) dut1 (
    .clk(clk), .reset(reset), .pred_req(pred_req), .pred_pc(pred_pc),
    .pred_valid(pv1), .prediction(pr1), .pred_idx(pi1),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .stat_clear(stat_clear), .stat_branches(sb1), .stat_mispred(sm1), .spec_ghr_o(sg1));

  gshare_predictor_param #(.MODE(2)) dut2 (
    .clk(clk), .reset(reset), .pred_req(pred_req), .pred_pc(pred_pc),
    .pred_valid(pv2), .prediction(pr2), .pred_idx(pi2),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .stat_clear(stat_clear), .stat_branches(sb2), .stat_mispred(sm2), .spec_ghr_o(sg2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic pr, input logic [7:0] pc, input logic uv, input logic [7:0] idx,
                     input logic t, input logic mp, input logic clr);
    pred_req = pr; pred_pc = pc; upd_valid = uv; upd_idx = idx;
    upd_taken = t; upd_mispredict = mp; stat_clear = clr;
    @(posedge clk); #1;
    if (verbose)
      $display("t=%0t req=%0b pc=%02h upd=%0b idx=%02h tk=%0b mp=%0b clr=%0b -> valid=%0b pred=%0b/%0b/%0b idx=%02h/%02h/%02h ghr=%02h br=%0d mp=%0d",
               $time, pr, pc, uv, idx, t, mp, clr, pv0, pr0, pr1, pr2, pi0, pi1, pi2, sg0, sb0, sm0);
    pred_req = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0; upd_mispredict = 1'b0; stat_clear = 1'b0;
  endtask

  task automatic pred(input logic [7:0] pc);
    cyc(1'b1, pc, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [7:0] idx, input logic t, input logic mp);
    cyc(1'b0, 8'h00, 1'b1, idx, t, mp, 1'b0);
  endtask

  task automatic hit_reset();
    #2 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; pred_req = 1'b0; pred_pc = '0; upd_valid = 1'b0; upd_idx = '0;
    upd_taken = 1'b0; upd_mispredict = 1'b0; stat_clear = 1'b0;

    // Reset state and first prediction
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", pv0, 0); check("rst_pred", pr0, 0); check("rst_idx", pi0, 0);
    check("rst_branches", sb0, 0); check("rst_mispred", sm0, 0); check("rst_ghr", sg0, 0);
    reset = 1'b1;
    pred(8'h05);
    check("p1_valid", pv0, 1); check("p1_pred", pr0, 0); check("p1_idx_gshare", pi0, 8'h05);
    check("p1_idx_gselect", pi1, 8'h50); check("p1_idx_bimodal", pi2, 8'h05);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("p1_valid_drop", pv0, 0); check("p1_idx_hold", pi0, 8'h05);

    // Counter saturation on the bimodal instance, index 0x10
    repeat (4) upd(8'h10, 1'b1, 1'b0);
    pred(8'h10); check("sat_hi_pred", pr2, 1); check("sat_hi_idx", pi2, 8'h10);
    upd(8'h10, 1'b0, 1'b0);
    pred(8'h10); check("one_nt_pred", pr2, 1);
    cyc(1'b1, 8'h10, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0); check("rbw_pred", pr2, 1);
    pred(8'h10); check("two_nt_pred", pr2, 0);
    repeat (2) upd(8'h10, 1'b0, 1'b0);
    pred(8'h10); check("sat_lo_pred", pr2, 0);
    repeat (3) upd(8'h10, 1'b0, 1'b0);
    upd(8'h10, 1'b1, 1'b0);
    pred(8'h10); check("sat_lo_climb1", pr2, 0);
    upd(8'h10, 1'b1, 1'b0);
    pred(8'h10); check("sat_lo_climb2", pr2, 1);

    // Statistics: 13 updates so far; 4-bit stats on the gselect instance saturate at 15
    check("stat_br13", sb0, 13); check("stat_mp0", sm0, 0);
    repeat (3) upd(8'h10, 1'b1, 1'b1);
    check("stat_br16", sb0, 16); check("stat_mp3", sm0, 3); check("stat_sat_br", sb1, 15);
    upd(8'h10, 1'b1, 1'b1);
    check("stat_sat_hold", sb1, 15); check("stat_mp4_small", sm1, 4);
    cyc(1'b0, 8'h00, 1'b1, 8'h10, 1'b1, 1'b1, 1'b1);
    check("clr_wins_br", sb0, 0); check("clr_wins_mp", sm0, 0);

    // Asynchronous reset between edges while a prediction is valid
    pred(8'h10); check("pre_rst_valid", pv2, 1); check("pre_rst_pred", pr2, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", pv2, 0); check("arst_pred", pr2, 0); check("arst_idx", pi2, 0); check("arst_ghr", sg2, 0);
    @(posedge clk); #1 reset = 1'b1;
    pred(8'h10); check("arst_pht_reinit", pr2, 0);

    // Speculative GHR built from taken predictions, then gshare/gselect indexing
    repeat (2) upd(8'h20, 1'b1, 1'b0);
    pred(8'h20); check("g_pred1", pr0, 1); check("g_idx1", pi0, 8'h20);
    pred(8'h21); check("g_pred2", pr0, 1); check("g_ghr3", sg0, 8'h03);
    pred(8'h0A); check("g_idx_xor", pi0, 8'h09); check("sel_idx_ghr0", pi1, 8'hA0);

    // Same GHR value on every instance via recovery, then compare indexing modes
    hit_reset();
    repeat (2) upd(8'h33, 1'b1, 1'b1);
    check("rec_ghr3_g", sg0, 8'h03); check("rec_ghr3_s", sg1, 8'h03);
    pred(8'h0A);
    check("g_idx_same", pi0, 8'h09); check("sel_idx", pi1, 8'hA3); check("bi_idx", pi2, 8'h0A);

    // Recovery racing a prediction: arch=0x01, spec=0x07
    hit_reset();
    upd(8'h40, 1'b1, 1'b1); check("r_mp1", sm0, 1);
    pred(8'h41); check("r_pred_a", pr0, 1);
    pred(8'h43); check("r_pred_b", pr0, 1); check("r_ghr7", sg0, 8'h07);
    cyc(1'b1, 8'h47, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    check("r_ghr_rec", sg0, 8'h02); check("r_pred_old", pr0, 1); check("r_idx_old", pi0, 8'h40);
    check("r_mp2", sm0, 2); check("r_br2", sb0, 2);
    pred(8'h00); check("r_idx_new", pi0, 8'h02);
    cyc(1'b0, 8'h00, 1'b0, 8'h40, 1'b1, 1'b1, 1'b0);
    check("mp_ignored", sm0, 2); check("mp_ignored_ghr", sg0, 8'h04);

    // Loop trace (9 taken, 1 not-taken). The all-taken history slot is shared by the
    // last two iterations; start it strongly taken so it settles on one miss per loop.
    hit_reset();
    repeat (2) upd(8'h7F, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) m_pht[i] = 2'd1;
    m_pht[8'h7F] = 2'd3;
    m_ghr = 8'h03; m_mp = 0; diverge = 0;
    verbose = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      tk = ((n % 10) != 9);
      m_idx = 8'h80 ^ m_ghr;
      m_pred = m_pht[m_idx][1];
      pred(8'h80);
      if ((pi0 !== m_idx) || (pr0 !== m_pred)) diverge++;
      upd(m_idx, tk, m_pred != tk);
      if (m_pred != tk) m_mp++;
      if (tk && (m_pht[m_idx] != 2'd3)) m_pht[m_idx] = m_pht[m_idx] + 2'd1;
      if (!tk && (m_pht[m_idx] != 2'd0)) m_pht[m_idx] = m_pht[m_idx] - 2'd1;
      m_ghr = {m_ghr[6:0], tk};
    end
    verbose = 1'b1;
    $display("trace: 1000 branches, model mispredicts=%0d, dut mispredicts=%0d", m_mp, sm0);
    check("trace_model_diverge", diverge, 0);
    check("trace_branches", sb0, 1000);
    check("trace_mispred", sm0, m_mp);
    check("trace_acc_ge85", (sm0 <= 32'd150), 1);
    check("trace_small_sat", sb1, 15);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("trace_clr_br", sb0, 0); check("trace_clr_mp", sm0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
